// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: multiply/divide opcodes and
// the sequencer state encoding.
package mips_pkg;

    // Operation select sampled together with start.
    localparam logic MD_MULTU = 1'b0;
    localparam logic MD_DIVU  = 1'b1;

    // Multiply/divide sequencer states.
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/multdiv_sequencer.sv
// Iterative unsigned MULTU/DIVU unit that owns the architectural HI/LO pair.
// It retires one bit per clock: shift-add for multiply, restoring division
// for divide. A zero divisor short-circuits after a single busy cycle.
//
// Handshake: start/op/srca/srcb form a request that is taken on any rising
// edge where start is high and the unit is not busy (state IDLE or DONE).
// While busy is high the request inputs are ignored and the operands are
// not re-sampled. done pulses for exactly one cycle once hi/lo hold the new
// result, and div_by_zero is meaningful only during that pulse.
module multdiv_sequencer
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_e          state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;      // multiplicand / dividend (shifts left in DIV)
    logic [WIDTH-1:0]   opb_q, opb_d;      // multiplier (shifts right in MUL) / divisor
    logic [2*WIDTH-1:0] acc_q, acc_d;      // product, or remainder:quotient
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;

    logic               accept;
    logic               last_iter;
    logic               divisor_zero;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;

    assign accept       = start && ((state_q == MD_IDLE) || (state_q == MD_DONE));
    assign last_iter    = (cnt_q == CW'(WIDTH - 1));
    assign divisor_zero = (opb_q == '0);

    // Shift-add step: add multiplicand into the upper half (carry kept in
    // bit WIDTH of the sum), then shift the whole accumulator right by one.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (opb_q[0] ? {1'b0, opa_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring-division step: bring the next dividend bit into the
    // remainder and trial-subtract the divisor; the extra top bit is the sign.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
    assign div_ok    = ~div_diff[WIDTH+1];
    assign div_rem   = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ok};

    // Next-state logic for the sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: begin
                if (accept) state_d = (op == MD_DIVU) ? MD_DIV : MD_MUL;
            end
            MD_MUL: begin
                if (last_iter) state_d = MD_DONE;
            end
            MD_DIV: begin
                if (divisor_zero || last_iter) state_d = MD_DONE;
            end
            MD_DONE: begin
                if (accept) state_d = (op == MD_DIVU) ? MD_DIV : MD_MUL;
                else        state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // Datapath next values: operand capture, one iteration per cycle, and
    // the HI/LO commit on the completing edge.
    always_comb begin
        opa_d = opa_q;
        opb_d = opb_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        dbz_d = 1'b0;
        if (accept) begin
            opa_d = srca;
            opb_d = srcb;
            acc_d = '0;
            cnt_d = '0;
        end else begin
            case (state_q)
                MD_MUL: begin
                    acc_d = mul_next;
                    opb_d = opb_q >> 1;
                    cnt_d = cnt_q + CW'(1);
                    if (last_iter) begin
                        hi_d = mul_next[2*WIDTH-1:WIDTH];
                        lo_d = mul_next[WIDTH-1:0];
                    end
                end
                MD_DIV: begin
                    if (divisor_zero) begin
                        hi_d  = opa_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        acc_d = div_next;
                        opa_d = opa_q << 1;
                        cnt_d = cnt_q + CW'(1);
                        if (last_iter) begin
                            hi_d = div_next[2*WIDTH-1:WIDTH];
                            lo_d = div_next[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= MD_IDLE;
        else       state_q <= state_d;
    end

    // Datapath and architectural HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opa_q <= '0;
            opb_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            dbz_q <= 1'b0;
        end else begin
            opa_q <= opa_d;
            opb_q <= opb_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            dbz_q <= dbz_d;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = (state_q == MD_MUL) || (state_q == MD_DIV);
    assign done        = (state_q == MD_DONE);
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Iterative unsigned multiply/divide unit for the MIPS core, producing the HI/LO register pair for MULTU and DIVU. It processes one bit per clock cycle.
- It sits beside the ALU in the datapath. The controller starts it with `start` and stalls PC/register writeback while `busy` is high.
- HI/LO hold their previous values until an operation completes. This block owns the architectural HI and LO registers.

Parameters:
- WIDTH, 32, operand width and number of iterations.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a new operation; sampled on the rising edge of clk
- op  in  1  0 = MULTU, 1 = DIVU; sampled together with start
- srca  in  WIDTH  multiplicand or dividend
- srcb  in  WIDTH  multiplier or divisor
- hi  out  WIDTH  HI register (upper product half, or remainder)
- lo  out  WIDTH  LO register (lower product half, or quotient)
- busy  out  1  operation in progress; the processor stalls while this is high
- done  out  1  one-cycle pulse: hi/lo were just updated
- div_by_zero  out  1  valid while done is high; DIVU with srcb == 0

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state = IDLE; hi = lo = 0; busy = 0; done = 0; div_by_zero = 0; iteration counter = 0.
  - Any operation in flight is aborted; no partial result is written.
- States: IDLE, MUL, DIV, DONE.
  - busy = (state is MUL or DIV).
  - done = (state is DONE).
- Start acceptance:
  - start is accepted only in IDLE or DONE. start while busy is ignored, and operands are not re-sampled.
  - On the accept edge E0: latch srca/srcb into internal operand registers, clear the accumulator and counter, go to MUL (op=0) or DIV (op=1).
- MUL (shift-add):
  - Each edge E1..E_WIDTH: if the multiplier LSB is 1, add the multiplicand into the upper half of a 2*WIDTH accumulator, keeping the carry. Then shift right by 1. Counter increments.
  - At edge E_WIDTH: hi = accumulator upper half, lo = lower half; go to DONE.
- DIV (restoring):
  - Each edge E1..E_WIDTH: shift remainder:quotient left by 1. Trial-subtract the divisor from the remainder (WIDTH+1 bits). If the result is non-negative, keep it and set the quotient LSB; otherwise restore.
  - At edge E_WIDTH: hi = remainder, lo = quotient; go to DONE.
- Divide by zero: DIVU with srcb == 0 skips iteration.
  - At edge E1: hi = srca, lo = all ones, div_by_zero = 1; go to DONE.
- Latency:
  - Normal operation: busy is high for exactly WIDTH cycles after E0; done is high for the single cycle after E_WIDTH.
  - Divide by zero: busy is high for 1 cycle.
- DONE: lasts one cycle.
  - If start is high, accept a new operation (same as IDLE) so back-to-back instructions lose no cycle.
  - Otherwise go to IDLE.
- hi/lo change only at completion edges or on reset. div_by_zero clears whenever state leaves DONE.
- Counter width is clog2(WIDTH)+1. The terminal condition is counter == WIDTH-1 at the iteration edge; there is no wrap.
- All arithmetic is unsigned. The product is the full 2*WIDTH bits; no overflow is possible.

Decomposition:
- Shared package (mips_pkg):
  - op encodings MD_MULTU=0, MD_DIVU=1
  - state encoding constants MD_IDLE, MD_MUL, MD_DIV, MD_DONE (2 bits)
- No sub-module. Datapath (accumulator, trial subtractor) and FSM live in one module, about 150–250 lines.

Test Plan:
- Reset, then MULTU 7 × 6 → busy for 32 cycles, done pulse once; hi=00000000, lo=0000002a.
- MULTU ffffffff × ffffffff → hi=fffffffe, lo=00000001; busy never drops early.
- DIVU 100 / 7 → lo=0000000e, hi=00000002, div_by_zero=0. Then, in the DONE cycle, start DIVU 0x80000000 / 3 → next result lo=2aaaaaaa, hi=00000002, with no idle cycle between.
- DIVU 12345678 / 0 → busy 1 cycle; done with div_by_zero=1, hi=12345678, lo=ffffffff.
- Start MULTU 3 × 5, pulse start with different operands at cycle 10 → ignored; result lo=0000000f. Assert reset at cycle 20 of a second MULTU → hi=lo=0, busy=0 immediately, with no done pulse.
- Hold start low after reset for 50 cycles → busy=0, done=0, hi=lo=0 throughout.
